alu_cmd_sched: RTL

Command scheduler that sits directly upstream of the combinational 8-bit ALU (alu).
- Accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle to the ALU's A/B/ALU_Sel inputs.
- Registers ALU_Out/CarryOut into an output stage with its own valid/ready handshake.
- Holds an accumulator so a command can chain on the previous result.

---
 rtl/alu_cmd_sched_pkg.sv | 35 +++
 rtl/alu_cmd_fifo.sv | 51 +++++
 rtl/alu_cmd_sched.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_cmd_sched_pkg.sv
// Shared definitions for the ALU command scheduler:
// opcodes, ALU width and command-word field layout.
package alu_cmd_sched_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // Command word is {use_acc, op, a, b}, b in the low bits.
  function automatic int cmd_w(input int w);
    return 2 * w + 4;
  endfunction

  function automatic int cmd_a_lsb(input int w);
    return w;
  endfunction

  function automatic int cmd_op_lsb(input int w);
    return 2 * w;
  endfunction

  function automatic int cmd_acc_bit(input int w);
    return 2 * w + 3;
  endfunction

  localparam int CMD_W = 2 * ALU_W + 4;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: circular buffer with occupancy count,
// head entry always visible on head_o.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            din_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DW-1:0]            head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_e, pop_e;

  assign full_o  = (cnt_q == FULL_N);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign push_e  = push_i && !full_o;
  assign pop_e   = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_e) wr_q <= wr_q + AW'(1);
      if (pop_e)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_e) - (AW+1)'(pop_e);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_e) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/alu_cmd_sched.sv
// ALU command scheduler: buffers commands, drives the
// external ALU from the FIFO head, registers its result.
module alu_cmd_sched
  import alu_cmd_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ALU_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  logic                   cmd_use_acc,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_carry,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic                   res_carry,
  output logic [WIDTH-1:0]       acc,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int EW   = cmd_w(WIDTH);
  localparam int AL   = cmd_a_lsb(WIDTH);
  localparam int OPL  = cmd_op_lsb(WIDTH);
  localparam int ACCB = cmd_acc_bit(WIDTH);

  logic [EW-1:0]    din, head;
  logic             full, empty, push, issue;
  logic             res_valid_q, res_carry_q;
  logic [WIDTH-1:0] res_data_q, acc_q;

  assign din       = {cmd_use_acc, cmd_op, cmd_a, cmd_b};
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign issue     = !empty && (!res_valid_q || res_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (issue),
    .din_i   (din),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count),
    .head_o  (head)
  );

  // Present the head command to the ALU; zeros when empty.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = OP_ADD;
    if (!empty) begin
      alu_sel = head[OPL +: 3];
      alu_b   = head[0 +: WIDTH];
      alu_a   = head[ACCB] ? acc_q : head[AL +: WIDTH];
    end
  end

  // Output stage and accumulator capture on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      acc_q       <= '0;
    end else if (issue) begin
      res_valid_q <= 1'b1;
      res_data_q  <= alu_out;
      res_carry_q <= alu_carry;
      acc_q       <= alu_out;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign acc       = acc_q;
  assign busy      = !empty || res_valid_q;

endmodule
